// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: operand issue and result bus signals for the bfloat16 add/sub sequencer
interface fp_addsub_seq_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        op_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic [2:0]  flags_o;
    logic        busy_o;

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, flags_o, busy_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, flags_o, busy_o
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle bfloat16 adder/subtractor; define FP_ADDSUB_RNE_EN for round-to-nearest-even (default truncates)
module fp_addsub_seq #(
    parameter int LZC_W = 4
) (
    input logic            clk_i,
    input logic            rst_ni,
    fp_addsub_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        sign_q, sign_d, sub_q, sub_d, nz_q, nz_d, inv_q, inv_d;
    logic        zero_q, zero_d, unf_q, unf_d, vld_q, vld_d;
    logic [9:0]  exp_q, exp_d;
    logic [10:0] ml_q, ml_d, ms_q, ms_d;
    logic [11:0] man_q, man_d;
    logic [15:0] res_q, res_d;
    logic [2:0]  flg_q, flg_d;

    logic [7:0] ea, eb, ma, mb, el, es, mlg, msm, diff;
    logic       swap;

    assign ea   = a_q[14:7];
    assign eb   = b_q[14:7];
    assign ma   = (ea == 8'd0) ? 8'd0 : {1'b1, a_q[6:0]};
    assign mb   = (eb == 8'd0) ? 8'd0 : {1'b1, b_q[6:0]};
    assign swap = {eb, mb} > {ea, ma};
    assign el   = swap ? eb : ea;
    assign es   = swap ? ea : eb;
    assign mlg  = swap ? mb : ma;
    assign msm  = swap ? ma : mb;
    assign diff = el - es;

    logic [LZC_W-1:0] lzc;

    // leading zeros of the 11-bit field below the carry bit; highest set bit wins
    always_comb begin
        lzc = LZC_W'(11);
        for (int i = 0; i <= 10; i++)
            if (man_q[i]) lzc = LZC_W'(10 - i);
    end

    logic [11:0] norm_m;
    logic [9:0]  norm_e;
    logic        ufl;

    assign norm_m = man_q[11] ? {1'b0, man_q[11:2], man_q[1] | man_q[0]} : man_q << lzc;
    assign norm_e = man_q[11] ? exp_q + 10'd1 : exp_q - 10'(lzc);
    assign ufl    = norm_e[9] | (norm_e == 10'd0);

    logic       inc;
    logic [8:0] rm9;
    logic [7:0] rfin;
    logic [9:0] re;
    logic       ovf;

`ifdef FP_ADDSUB_RNE_EN
    assign inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
    assign inc = 1'b0;
`endif
    assign rm9  = {1'b0, man_q[10:3]} + 9'(inc);
    assign rfin = rm9[8] ? rm9[8:1] : rm9[7:0];
    assign re   = rm9[8] ? exp_q + 10'd1 : exp_q;
    assign ovf  = re >= 10'd255;

    // sequencer: one step of the add/sub pipeline per state, result held in DONE until taken
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        nz_d    = nz_q;
        inv_d   = inv_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        vld_d   = vld_q;
        exp_d   = exp_q;
        ml_d    = ml_q;
        ms_d    = ms_q;
        man_d   = man_q;
        res_d   = res_q;
        flg_d   = flg_q;
        case (state_q)
            S_IDLE: if (bus.in_valid_i) begin
                a_d     = bus.a_i;
                b_d     = {bus.b_i[15] ^ bus.op_i, bus.b_i[14:0]};
                state_d = S_ALIGN;
            end
            S_ALIGN: begin
                ml_d    = {mlg, 3'b000};
                ms_d    = (diff > 8'd8) ? 11'd0 : ({msm, 3'b000} >> diff);
                exp_d   = {2'b00, el};
                sign_d  = swap ? b_q[15] : a_q[15];
                sub_d   = a_q[15] ^ b_q[15];
                nz_d    = (ea == 8'd0) & (eb == 8'd0) & a_q[15] & b_q[15];
                inv_d   = (ea == 8'hFF) | (eb == 8'hFF);
                state_d = S_ADD;
            end
            S_ADD: begin
                man_d   = sub_q ? {1'b0, ml_q} - {1'b0, ms_q} : {1'b0, ml_q} + {1'b0, ms_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                man_d   = norm_m;
                exp_d   = norm_e;
                zero_d  = (man_q == 12'd0) | ufl;
                unf_d   = (man_q != 12'd0) & ufl;
                sign_d  = (man_q == 12'd0) ? nz_q : sign_q;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d   = inv_q  ? 16'h7FC0 :
                          zero_q ? {sign_q, 15'd0} :
                          ovf    ? {sign_q, 8'hFF, 7'd0} : {sign_q, re[7:0], rfin[6:0]};
                flg_d   = {inv_q, ~inv_q & ~zero_q & ovf, ~inv_q & unf_q};
                state_d = S_DONE;
            end
            S_DONE: begin
                vld_d = 1'b1;
                if (vld_q & bus.out_ready_i) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers; reset drops any operation in flight
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            nz_q    <= 1'b0;
            inv_q   <= 1'b0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            vld_q   <= 1'b0;
            exp_q   <= '0;
            ml_q    <= '0;
            ms_q    <= '0;
            man_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            nz_q    <= nz_d;
            inv_q   <= inv_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            ml_q    <= ml_d;
            ms_q    <= ms_d;
            man_q   <= man_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign bus.in_ready_o  = state_q == S_IDLE;
    assign bus.busy_o      = state_q != S_IDLE;
    assign bus.out_valid_o = vld_q;
    assign bus.result_o    = res_q;
    assign bus.flags_o     = flg_q;
endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Multi-cycle sequencer for a bfloat16 adder/subtractor (1 sign, 8 exp, 7 frac, hidden bit).
- Unpacks and orders the operands, then drives the mantissa alignment shifter (8-bit mantissa, 8-bit exponent difference, 11-bit aligned output with 3 guard bits).
- Adds or subtracts, normalizes and rounds, then returns the result over a valid/ready handshake.
- Sits between the operand issue logic and the FP result bus; one operation in flight at a time.

Parameters:
- LZC_W, 4, width of the leading-zero count used in normalization (covers a 12-bit sum).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept an operation; high only in IDLE.
- a_i  in  16  operand A, bfloat16.
- b_i  in  16  operand B, bfloat16.
- op_i  in  1  0 = A+B, 1 = A−B (B sign inverted at accept).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  16  bfloat16 result.
- flags_o  out  3  {invalid, overflow, underflow}; valid with out_valid_o.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_ni low at edge): state IDLE; in_ready_o=1 after reset; out_valid_o=0; result_o=16'h0000; flags_o=0; busy_o=0. Reset mid-operation drops the operation with no output.
- States: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
- IDLE: on in_valid_i & in_ready_o, register operands and op_i. Exp 0 means zero (hidden bit 0, fraction ignored, denormals flushed).
- ALIGN: swap so A has the larger magnitude (compare exp, then mantissa). diff = expA − expB.
  - Aligned B = {mantB,000} >> diff for diff 0..8; diff > 8 gives 0.
  - A extended to {mantA,3'b000}.
  - Effective subtract = signA XOR signB(after op).
- ADD: 12-bit sum/difference of the 11-bit values; result sign = sign of A.
- NORM:
  - Carry bit set: shift right 1, OR the dropped bit into bit0, exp+1.
  - Otherwise: shift left by the leading-zero count, exp − lzc.
  - Sum zero: result +0; −0 only when both inputs are negative zero on an effective add.
  - exp − lzc ≤ 0: flush to signed zero, underflow=1.
- ROUND: mantissa = bits[10:3]; G, R, S = bits 2, 1, 0 (rounding per the optional feature).
  - Mantissa overflow after rounding: shift right, exp+1.
  - exp ≥ 255: result ±inf (exp 255, frac 0), overflow=1.
- Specials (detected at ALIGN): either input exp=255 gives result 16'h7FC0 and invalid=1. NORM/ROUND logic still steps, so latency is unchanged.
- DONE: out_valid_o=1. result_o and flags_o are stable until out_ready_i is high at an edge, then the block returns to IDLE.
- No new accept occurs in the same cycle as the result is consumed.
- Latency: accept edge t, out_valid_o high after edge t+5. Throughput is at most one operation per 6 cycles.
- in_valid_i outside IDLE is ignored. Operand inputs are only sampled at accept.

Optional Feature:
- Macro FP_ADDSUB_RNE_EN.
- Defined: round-to-nearest-even. Increment the mantissa when G & (R | S | mant[0]).
- Undefined: truncation; G, R and S are discarded. Overflow from rounding cannot occur.
- Latency is identical in both builds.

Test Plan:
- Reset mid-ALIGN with rst_ni=0 for 1 cycle -> IDLE, out_valid_o never rises, in_ready_o=1 next cycle.
- a=0x3F80 (1.0), b=0x4000 (2.0), op=0 -> result 0x4040, flags 000, out_valid_o exactly 5 cycles after the accept edge.
- a=0x3F80, b=0x3F80, op=1 -> result 0x0000 (+0), flags 000.
- a=0x4381 (258), b=0x3F80 (1.0), op=0 -> RNE build 0x4382; truncation build 0x4381.
- a=0x7F7F, b=0x7F7F, op=0 -> 0x7F80, overflow=1. a=0x7FC0, b=0x3F80 -> 0x7FC0, invalid=1.
- Backpressure: out_ready_i=0 for 3 cycles in DONE -> result_o/flags_o held, in_ready_o=0, new in_valid_i ignored. Release -> IDLE next cycle.
